// File: rtl/fetch_decode_buffer_if.sv
// Handshake bundle between the fetch stage, the fetch/decode buffer and the decode stage.
// The master side represents fetch plus decode together; the buffer itself takes the slave side.
interface fetch_decode_buffer_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                   i_flush;
  logic                   i_valid;
  logic                   o_ready;
  logic [INSTR_WIDTH-1:0] i_instr;
  logic [ADDR_WIDTH-1:0]  i_pc;
  logic [ADDR_WIDTH-1:0]  i_pc_plus4;
  logic                   o_valid;
  logic                   i_ready;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0]  o_pc;
  logic [ADDR_WIDTH-1:0]  o_pc_plus4;
  logic [6:0]             o_op;
  logic [CNT_W-1:0]       o_count;

  modport master (
    output i_flush, i_valid, i_instr, i_pc, i_pc_plus4, i_ready,
    input  o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_op, o_count
  );

  modport slave (
    input  i_flush, i_valid, i_instr, i_pc, i_pc_plus4, i_ready,
    output o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_op, o_count
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Small FIFO of {instr, pc, pc+4} between fetch and decode; no fall-through, flush drops everything.
// An empty buffer presents a NOP bubble (addi x0,x0,0) so the decoder issues a harmless write to x0.
module fetch_decode_buffer #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 2
) (
  input logic                  i_clk,
  input logic                  i_arstn,
  fetch_decode_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc4_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic not_full;
  logic not_empty;
  logic push;
  logic pop;

  logic [INSTR_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [ADDR_WIDTH-1:0]  head_pc4;

  assign not_full  = (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = bus.i_valid & not_full;
  assign pop       = not_empty & bus.i_ready;

  // Occupancy and pointers; flush outranks any same-cycle push or pop.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage is deliberately left unreset; only occupancy decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push && !bus.i_flush) begin
      instr_mem[wr_ptr] <= bus.i_instr;
      pc_mem[wr_ptr]    <= bus.i_pc;
      pc4_mem[wr_ptr]   <= bus.i_pc_plus4;
    end
  end

  // Head selection with bubble substitution when empty.
  always_comb begin
    head_instr = NOP_INSTR;
    head_pc    = '0;
    head_pc4   = '0;
    if (not_empty) begin
      head_instr = instr_mem[rd_ptr];
      head_pc    = pc_mem[rd_ptr];
      head_pc4   = pc4_mem[rd_ptr];
    end
  end

  assign bus.o_ready    = not_full;
  assign bus.o_valid    = not_empty;
  assign bus.o_instr    = head_instr;
  assign bus.o_pc       = head_pc;
  assign bus.o_pc_plus4 = head_pc4;
  assign bus.o_op       = head_instr[6:0];
  assign bus.o_count    = count;
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer (DEPTH=2): reset, latency, full/stall, streaming wrap, flush, async reset.
module tb_fetch_decode_buffer;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned DP = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic arstn;
  int   n_cmp;
  int   n_err;

  fetch_decode_buffer_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DP)) bus ();

  fetch_decode_buffer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DP)) dut (
    .i_clk  (clk),
    .i_arstn(arstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, ".ready"}, 64'(bus.o_ready), 64'd1);
    chk({tag, ".instr"}, 64'(bus.o_instr), 64'(NOP));
    chk({tag, ".op"},    64'(bus.o_op),    64'h13);
    chk({tag, ".pc"},    bus.o_pc,         64'd0);
    chk({tag, ".pc4"},   bus.o_pc_plus4,   64'd0);
    chk({tag, ".count"}, 64'(bus.o_count), 64'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                          input int cnt);
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'd1);
    chk({tag, ".instr"}, 64'(bus.o_instr), 64'(instr));
    chk({tag, ".op"},    64'(bus.o_op),    64'(instr[6:0]));
    chk({tag, ".pc"},    bus.o_pc,         pc);
    chk({tag, ".pc4"},   bus.o_pc_plus4,   pc + 64'd4);
    chk({tag, ".count"}, 64'(bus.o_count), 64'(cnt));
    chk({tag, ".ready"}, 64'(bus.o_ready), (cnt < 2) ? 64'd1 : 64'd0);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [63:0] pc);
    bus.i_valid    = 1'b1;
    bus.i_instr    = instr;
    bus.i_pc       = pc;
    bus.i_pc_plus4 = pc + 64'd4;
  endtask

  initial begin
    logic [31:0] ins_a;
    logic [31:0] ins_b;
    logic [31:0] ins_c;
    logic [31:0] ins_d;
    logic [31:0] ins_k;
    n_cmp          = 0;
    n_err          = 0;
    arstn          = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.i_instr    = '0;
    bus.i_pc       = '0;
    bus.i_pc_plus4 = '0;
    ins_a = 32'h0050_0093;
    ins_b = 32'h00a0_0113;
    ins_c = 32'h0020_81b3;
    ins_d = 32'h0020_8463;

    // Reset values
    #2;
    chk_empty("reset");
    #10;
    arstn = 1'b1;
    tick();
    chk_empty("post_reset");

    // Single push, no fall-through
    drive(ins_a, 64'h1000);
    #1;
    chk("no_fallthrough.valid", 64'(bus.o_valid), 64'd0);
    tick();
    bus.i_valid = 1'b0;
    chk_head("single", ins_a, 64'h1000, 1);
    chk("single.op_hex", 64'(bus.o_op), 64'h13);

    // Drain A, then fill with B, C and hold D while full
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk_empty("pop_a");
    drive(ins_b, 64'h2000);
    tick();
    chk_head("fill1", ins_b, 64'h2000, 1);
    drive(ins_c, 64'h2004);
    tick();
    chk_head("fill2", ins_b, 64'h2000, 2);
    drive(ins_d, 64'h2008);
    tick();
    chk_head("full_hold", ins_b, 64'h2000, 2);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk_head("pop_while_full", ins_c, 64'h2004, 1);
    chk("pop_while_full.op", 64'(bus.o_op), 64'h33);
    tick();
    bus.i_valid = 1'b0;
    chk_head("d_accepted", ins_c, 64'h2004, 2);
    bus.i_ready = 1'b1;
    tick();
    chk_head("drain_d", ins_d, 64'h2008, 1);
    tick();
    bus.i_ready = 1'b0;
    chk_empty("drained");

    // Streaming: simultaneous push/pop holds count at 1 across pointer wrap
    bus.i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ins_k = 32'h0000_0033 | (32'(k) << 15);
      drive(ins_k, 64'h3000 + 64'(4 * k));
      tick();
      chk_head($sformatf("stream%0d", k), ins_k, 64'h3000 + 64'(4 * k), 1);
    end
    bus.i_valid = 1'b0;
    tick();
    bus.i_ready = 1'b0;
    chk_empty("stream_end");

    // Flush while full with a pending push
    drive(32'h0010_0013, 64'h4000);
    tick();
    drive(32'h0020_0013, 64'h4004);
    tick();
    chk_head("pre_flush", 32'h0010_0013, 64'h4000, 2);
    drive(32'h0030_0013, 64'h4008);
    bus.i_flush = 1'b1;
    tick();
    chk_empty("flush_full");
    tick();
    chk_empty("flush_push_dropped");
    bus.i_flush = 1'b0;
    tick();
    bus.i_valid = 1'b0;
    chk_head("post_flush", 32'h0030_0013, 64'h4008, 1);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk_empty("post_flush_drain");

    // Asynchronous reset mid-cycle with two entries queued
    drive(32'h0040_0013, 64'h5000);
    tick();
    drive(32'h0050_0013, 64'h5004);
    tick();
    bus.i_valid = 1'b0;
    chk_head("pre_arst", 32'h0040_0013, 64'h5000, 2);
    #2;
    arstn = 1'b0;
    #1;
    chk_empty("async_reset");
    #2;
    arstn = 1'b1;
    tick();
    chk_empty("after_async_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
